// File: rtl/mem_port_arbiter_if.sv
// Bundle of every non-clock/reset signal of mem_port_arbiter.
//   slave  : arbiter view (takes IF/MEM requests and bridge responses,
//            drives address/data acknowledges, the bridge request and resp_err)
//   master : environment view (requesters plus bridge), the mirror of slave
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // IF-stage requester
    logic                inst_req;
    logic [ADDR_W-1:0]   inst_addr;
    logic                inst_addr_ok;
    logic                inst_data_ok;
    logic [DATA_W-1:0]   inst_rdata;
    // MEM-stage requester
    logic                data_req;
    logic                data_wr;
    logic [DATA_W/8-1:0] data_wstrb;
    logic [ADDR_W-1:0]   data_addr;
    logic [DATA_W-1:0]   data_wdata;
    logic                data_addr_ok;
    logic                data_data_ok;
    logic [DATA_W-1:0]   data_rdata;
    // memory bridge
    logic                mem_req;
    logic                mem_wr;
    logic [DATA_W/8-1:0] mem_wstrb;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_addr_ok;
    logic                mem_data_ok;
    logic [DATA_W-1:0]   mem_rdata;
    // status
    logic                resp_err;

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata,
        output resp_err
    );

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata,
        input  resp_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between the IF-stage instruction requester
// and the MEM-stage data requester. A grant is locked until its address phase
// is accepted; a small in-order FIFO of source IDs routes every bridge response
// back to the requester that issued it.
// Ports:
//   clk    : clock, rising edge
//   resetn : asynchronous reset, active low
//   bus    : mem_port_arbiter_if.slave (requesters, bridge, resp_err)
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_OUTST  = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    mem_port_arbiter_if.slave     bus
);
    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam int ST_W  = $clog2(STARVE_LIM + 1);

    typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;

    state_t               state_q, state_d;
    logic [MAX_OUTST-1:0] src_q, src_d;       // source ID per slot: 0=inst, 1=data
    logic [PTR_W-1:0]     wptr_q, wptr_d;
    logic [PTR_W-1:0]     rptr_q, rptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ST_W-1:0]      starve_q, starve_d;
    logic                 resp_err_q, resp_err_d;

    logic gnt_i, gnt_d, issue, pop, head_src, full, starved;

    // Full uses the registered count only, so a response in this cycle never
    // opens a slot for an issue in the same cycle.
    assign full    = (cnt_q == CNT_W'(MAX_OUTST));
    assign starved = (starve_q == ST_W'(STARVE_LIM));

    // Grant and next state
    always_comb begin
        gnt_i   = 1'b0;
        gnt_d   = 1'b0;
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!full) begin
                    if (bus.data_req && !(starved && bus.inst_req)) gnt_d = 1'b1;
                    else if (bus.inst_req)                           gnt_i = 1'b1;
                end
            end
            LOCK_I:  gnt_i = 1'b1;
            LOCK_D:  gnt_d = 1'b1;
            default: ;
        endcase
        // Requests are forced off while reset is held so the bridge sees
        // nothing even if the stages keep their requests up.
        if (!resetn) begin
            gnt_i = 1'b0;
            gnt_d = 1'b0;
        end
        if (bus.mem_req && !bus.mem_addr_ok) state_d = gnt_d ? LOCK_D : LOCK_I;
        else                                 state_d = IDLE;
    end

    // Bridge request mux
    always_comb begin
        bus.mem_req   = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_wstrb = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (gnt_d) begin
            bus.mem_req   = bus.data_req;
            bus.mem_wr    = bus.data_wr;
            bus.mem_wstrb = bus.data_wr ? bus.data_wstrb : '0;
            bus.mem_addr  = bus.data_addr;
            bus.mem_wdata = bus.data_wdata;
        end else if (gnt_i) begin
            bus.mem_req   = bus.inst_req;
            bus.mem_addr  = bus.inst_addr;
        end
    end

    assign issue            = bus.mem_req && bus.mem_addr_ok;
    assign bus.inst_addr_ok = issue && gnt_i;
    assign bus.data_addr_ok = issue && gnt_d;

    // Response routing: zero latency from mem_data_ok to the head owner
    assign pop              = bus.mem_data_ok && (cnt_q != '0);
    assign head_src         = src_q[rptr_q];
    assign bus.inst_data_ok = pop && !head_src;
    assign bus.data_data_ok = pop &&  head_src;
    assign bus.inst_rdata   = bus.mem_rdata;
    assign bus.data_rdata   = bus.mem_rdata;
    assign bus.resp_err     = resp_err_q;

    // Source-ID FIFO, starvation counter, error flag
    always_comb begin
        src_d      = src_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q;
        starve_d   = starve_q;
        resp_err_d = resp_err_q;

        if (issue) begin
            src_d[wptr_q] = gnt_d;
            wptr_d        = wptr_q + PTR_W'(1);
        end
        if (pop) rptr_d = rptr_q + PTR_W'(1);
        if (issue && !pop)      cnt_d = cnt_q + CNT_W'(1);
        else if (!issue && pop) cnt_d = cnt_q - CNT_W'(1);

        if (bus.mem_data_ok && (cnt_q == '0)) resp_err_d = 1'b1;

        if (!bus.inst_req || (issue && gnt_i))            starve_d = '0;
        else if (issue && gnt_d && !starved)              starve_d = starve_q + ST_W'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            src_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            starve_q   <= '0;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
            resp_err_q <= resp_err_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    localparam logic [31:0] IADDR = 32'h1C00_0000;
    localparam logic [31:0] DADDR = 32'h0000_0100;

    logic clk, resetn;
    int   n_chk, n_fail;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTST(2), .STARVE_LIM(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ir, dr, dw, aok, dok;
        logic [31:0] rdata;
        logic        mreq, mwr;
        logic [1:0]  gnt;               // 0 none, 1 inst, 2 data
        logic        iaok, daok, idok, ddok, err;
    } vec_t;

    vec_t tv[25];

    function automatic vec_t mk(logic ir, logic dr, logic dw, logic aok, logic dok,
                                logic [31:0] rd, logic mreq, logic mwr, logic [1:0] gnt,
                                logic iaok, logic daok, logic idok, logic ddok, logic err);
        vec_t v;
        v.ir = ir; v.dr = dr; v.dw = dw; v.aok = aok; v.dok = dok; v.rdata = rd;
        v.mreq = mreq; v.mwr = mwr; v.gnt = gnt; v.iaok = iaok; v.daok = daok;
        v.idok = idok; v.ddok = ddok; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic dr, input logic dw,
                         input logic aok, input logic dok, input logic [31:0] rd);
        bus.inst_req    = ir;
        bus.data_req    = dr;
        bus.data_wr     = dw;
        bus.mem_addr_ok = aok;
        bus.mem_data_ok = dok;
        bus.mem_rdata   = rd;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        bus.inst_addr  = IADDR;
        bus.data_addr  = DADDR;
        bus.data_wstrb = 4'hF;
        bus.data_wdata = 32'hDEAD_BEEF;
        drive(1, 1, 1, 1, 0, 0);
        resetn = 1'b0;

        // reset state with both requests held high
        @(negedge clk); #2;
        chk("rst_mem_req",  0, 32'(bus.mem_req),      0);
        chk("rst_mem_wstrb",0, 32'(bus.mem_wstrb),    0);
        chk("rst_iaok",     0, 32'(bus.inst_addr_ok), 0);
        chk("rst_daok",     0, 32'(bus.data_addr_ok), 0);
        chk("rst_err",      0, 32'(bus.resp_err),     0);
        @(negedge clk);
        resetn = 1'b1;
        drive(0, 0, 0, 0, 0, 0);

        //          ir dr dw ak dk rdata         mrq mwr g  ia da id dd er
        tv[0]  = mk(1, 0, 0, 1, 0, 32'h0,        1,  0,  1, 1, 0, 0, 0, 0); // inst only
        tv[1]  = mk(0, 0, 0, 0, 0, 32'h0,        0,  0,  0, 0, 0, 0, 0, 0);
        tv[2]  = mk(0, 0, 0, 0, 1, 32'hA5A5A5A5, 0,  0,  0, 0, 0, 1, 0, 0);
        tv[3]  = mk(1, 1, 1, 1, 0, 32'h0,        1,  1,  2, 0, 1, 0, 0, 0); // both: data first
        tv[4]  = mk(1, 0, 0, 1, 0, 32'h0,        1,  0,  1, 1, 0, 0, 0, 0);
        tv[5]  = mk(0, 0, 0, 0, 1, 32'h11111111, 0,  0,  0, 0, 0, 0, 1, 0);
        tv[6]  = mk(0, 0, 0, 0, 1, 32'h22222222, 0,  0,  0, 0, 0, 1, 0, 0);
        tv[7]  = mk(0, 1, 0, 0, 0, 32'h0,        1,  0,  2, 0, 0, 0, 0, 0); // LOCK_D
        tv[8]  = mk(1, 1, 0, 0, 0, 32'h0,        1,  0,  2, 0, 0, 0, 0, 0);
        tv[9]  = mk(1, 1, 0, 0, 0, 32'h0,        1,  0,  2, 0, 0, 0, 0, 0);
        tv[10] = mk(1, 1, 0, 1, 0, 32'h0,        1,  0,  2, 0, 1, 0, 0, 0);
        tv[11] = mk(1, 0, 0, 1, 0, 32'h0,        1,  0,  1, 1, 0, 0, 0, 0);
        tv[12] = mk(1, 1, 0, 1, 0, 32'h0,        0,  0,  0, 0, 0, 0, 0, 0); // full
        tv[13] = mk(1, 1, 0, 1, 1, 32'h33333333, 0,  0,  0, 0, 0, 0, 1, 0); // pop, still blocked
        tv[14] = mk(1, 1, 0, 1, 0, 32'h0,        1,  0,  2, 0, 1, 0, 0, 0);
        tv[15] = mk(0, 0, 0, 0, 1, 32'h44444444, 0,  0,  0, 0, 0, 1, 0, 0);
        tv[16] = mk(0, 0, 0, 0, 1, 32'h55555555, 0,  0,  0, 0, 0, 0, 1, 0);
        tv[17] = mk(0, 0, 0, 0, 1, 32'h66666666, 0,  0,  0, 0, 0, 0, 0, 0); // empty pop
        tv[18] = mk(0, 0, 0, 0, 0, 32'h0,        0,  0,  0, 0, 0, 0, 0, 1);
        tv[19] = mk(1, 0, 0, 0, 0, 32'h0,        1,  0,  1, 0, 0, 0, 0, 1); // LOCK_I
        tv[20] = mk(1, 1, 0, 0, 0, 32'h0,        1,  0,  1, 0, 0, 0, 0, 1);
        tv[21] = mk(1, 1, 0, 1, 0, 32'h0,        1,  0,  1, 1, 0, 0, 0, 1);
        tv[22] = mk(0, 1, 1, 1, 0, 32'h0,        1,  1,  2, 0, 1, 0, 0, 1);
        tv[23] = mk(0, 0, 0, 0, 1, 32'h77777777, 0,  0,  0, 0, 0, 1, 0, 1);
        tv[24] = mk(0, 0, 0, 0, 1, 32'h88888888, 0,  0,  0, 0, 0, 0, 1, 1);

        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            drive(tv[i].ir, tv[i].dr, tv[i].dw, tv[i].aok, tv[i].dok, tv[i].rdata);
            #2;
            chk("mem_req",   i, 32'(bus.mem_req),      32'(tv[i].mreq));
            chk("mem_wr",    i, 32'(bus.mem_wr),       32'(tv[i].mwr));
            chk("mem_wstrb", i, 32'(bus.mem_wstrb),    tv[i].mwr ? 32'hF : 32'h0);
            if (tv[i].gnt != 2'd0)
                chk("mem_addr", i, bus.mem_addr, (tv[i].gnt == 2'd1) ? IADDR : DADDR);
            chk("inst_addr_ok", i, 32'(bus.inst_addr_ok), 32'(tv[i].iaok));
            chk("data_addr_ok", i, 32'(bus.data_addr_ok), 32'(tv[i].daok));
            chk("inst_data_ok", i, 32'(bus.inst_data_ok), 32'(tv[i].idok));
            chk("data_data_ok", i, 32'(bus.data_data_ok), 32'(tv[i].ddok));
            chk("resp_err",     i, 32'(bus.resp_err),     32'(tv[i].err));
            if (tv[i].idok) chk("inst_rdata", i, bus.inst_rdata, tv[i].rdata);
            if (tv[i].ddok) chk("data_rdata", i, bus.data_rdata, tv[i].rdata);
        end

        // starvation: both requests held, bridge always accepts and answers the
        // previous issue every cycle -> repeating 4 data, 1 inst
        @(negedge clk);
        resetn = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            drive(1, 1, 0, 1, (k > 0), 32'(k));
            #2;
            chk("starve_iaok", k, 32'(bus.inst_addr_ok), (k % 5 == 4) ? 32'd1 : 32'd0);
            chk("starve_daok", k, 32'(bus.data_addr_ok), (k % 5 == 4) ? 32'd0 : 32'd1);
        end

        // reset in the middle of a transaction
        @(negedge clk);
        drive(1, 0, 0, 1, 0, 0);
        #2;
        chk("mid_iaok_pre", 0, 32'(bus.inst_addr_ok), 1);
        #1 resetn = 1'b0;
        #1;
        chk("mid_rst_mem_req", 0, 32'(bus.mem_req),      0);
        chk("mid_rst_iaok",    0, 32'(bus.inst_addr_ok), 0);
        chk("mid_rst_idok",    0, 32'(bus.inst_data_ok), 0);
        chk("mid_rst_err",     0, 32'(bus.resp_err),     0);
        @(negedge clk);
        resetn = 1'b1;
        drive(0, 0, 0, 0, 1, 32'h9999_9999);       // late bridge response
        #2;
        chk("late_idok", 0, 32'(bus.inst_data_ok), 0);
        chk("late_ddok", 0, 32'(bus.data_data_ok), 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #2;
        chk("late_err", 0, 32'(bus.resp_err), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
